// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: prefetcher request types, AXI encodings and the
// read-bridge FSM state encoding.
package cpu_pkg;

  localparam logic [1:0] RD_UNCACHE = 2'b00;
  localparam logic [1:0] RD_LINE    = 2'b01;
  localparam logic [1:0] RD_2LINE   = 2'b10;
  localparam logic [1:0] RD_RSVD    = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_AR   = 4'b0010,
    ST_R    = 4'b0100,
    ST_DONE = 4'b1000
  } rd_state_e;

  // Reserved type 11 is issued as a single line.
  function automatic logic [7:0] rd_arlen(input logic [1:0] t);
    case (t)
      RD_UNCACHE: rd_arlen = 8'd0;
      RD_2LINE:   rd_arlen = 8'd7;
      default:    rd_arlen = 8'd3;
    endcase
  endfunction

  function automatic logic [31:0] rd_araddr(input logic [1:0] t, input logic [31:0] a);
    if (t == RD_UNCACHE) rd_araddr = a;
    else                 rd_araddr = {a[31:4], 4'b0000};
  endfunction

endpackage

// File: rtl/axi_rd_bridge.sv
// AXI read-channel master for the dcache prefetcher: one request in flight, one AR
// burst per request, R beats packed into a 256-bit return register.
module axi_rd_bridge
  import cpu_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd3,
  parameter logic [3:0] UC_ARCACHE = 4'b0000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [1:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_half,
  output logic [255:0] ret_data,
  output logic         ret_err,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [1:0]   arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  rd_state_e      r_state;
  rd_state_e      w_next;
  logic [1:0]     r_type;
  logic [31:0]    r_addr;
  logic [2:0]     r_cnt;
  logic           r_err;
  logic           r_over;
  logic           r_half;
  logic [255:0]   r_data;

  logic           w_accept;
  logic           w_beat;
  logic [7:0]     w_arlen;
  logic           w_cnt_last;
  logic           w_unused_rid;

  assign w_accept     = (r_state == ST_IDLE) && rd_req;
  assign w_beat       = (r_state == ST_R) && rvalid;
  assign w_arlen      = rd_arlen(r_type);
  assign w_cnt_last   = (r_cnt == w_arlen[2:0]);
  assign w_unused_rid = ^rid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (rd_req)           w_next = ST_AR;
      ST_AR:   if (arready)          w_next = ST_R;
      ST_R:    if (rvalid && rlast)  w_next = ST_DONE;
      ST_DONE:                       w_next = ST_IDLE;
      default:                       w_next = ST_IDLE;
    endcase
  end

  // r_over marks that the beat at index arlen has been taken; any further beat
  // before rlast is a count fault and must not re-trigger ret_half.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_type <= RD_UNCACHE;
      r_addr <= 32'd0;
      r_cnt  <= 3'd0;
      r_err  <= 1'b0;
      r_over <= 1'b0;
      r_half <= 1'b0;
      r_data <= '0;
    end else begin
      r_half <= 1'b0;
      if (w_accept) begin
        r_type <= rd_type;
        r_addr <= rd_addr;
        r_cnt  <= 3'd0;
        r_err  <= 1'b0;
        r_over <= 1'b0;
      end
      if (w_beat) begin
        r_data[{r_cnt, 5'b00000} +: 32] <= rdata;
        r_cnt <= r_cnt + 3'd1;
        if (w_cnt_last) r_over <= 1'b1;
        if ((rresp != RESP_OKAY) || r_over || (rlast && !w_cnt_last)) r_err <= 1'b1;
        if ((r_type == RD_2LINE) && (r_cnt == 3'd3) && !r_over) r_half <= 1'b1;
      end
    end
  end

  assign rd_rdy    = (r_state == ST_IDLE);
  assign arvalid   = (r_state == ST_AR);
  assign rready    = (r_state == ST_R);
  assign ret_valid = (r_state == ST_DONE);
  assign ret_err   = (r_state == ST_DONE) && (r_err || (r_type == RD_RSVD));
  assign ret_half  = r_half;
  assign ret_data  = r_data;

  assign arid    = AXI_ID;
  assign araddr  = rd_araddr(r_type, r_addr);
  assign arlen   = w_arlen;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = (r_type == RD_UNCACHE) ? UC_ARCACHE : 4'b1111;
  assign arprot  = 3'b000;

endmodule

// File: tb/tb_axi_rd_bridge.sv
// Bench for axi_rd_bridge: an AXI slave driver plus a transaction-level model that
// predicts every handshake-visible output cycle by cycle.
module tb_axi_rd_bridge;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rd_req = 1'b0;
  logic [1:0]   rd_type = 2'b00;
  logic [31:0]  rd_addr = 32'd0;
  logic         rd_rdy, ret_valid, ret_half, ret_err;
  logic [255:0] ret_data;
  logic [3:0]   arid, arcache;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, arlock;
  logic         arvalid, rready;
  logic         arready = 1'b0;
  logic [3:0]   rid = 4'd3;
  logic [31:0]  rdata = 32'd0;
  logic [1:0]   rresp = 2'b00;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;

  axi_rd_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_half(ret_half), .ret_data(ret_data), .ret_err(ret_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: expected control outputs for the current cycle, and the request in flight.
  bit           e_rdy = 1, e_arv = 0, e_rr = 0, e_val = 0, e_half = 0;
  logic [255:0] m_data = '0;
  logic [31:0]  m_araddr = 32'd0;
  int           m_arlen = 0;
  logic [3:0]   m_cache = 4'd0;
  logic [1:0]   m_type = 2'd0;
  bit           m_err = 0;
  int           m_beats = 0;

  logic [31:0]  cap_araddr;
  logic [7:0]   cap_arlen;
  logic [255:0] cap_data;
  logic         cap_err;
  int           cyc = 0, cyc_half = 0, cyc_valid = 0, n_half = 0, n_valid = 0;

  always @(negedge clk) begin
    bit nx_rdy, nx_arv, nx_rr, nx_val, nx_half;
    cyc++;
    if (!resetn) begin
      chk("rst_rd_rdy", rd_rdy, 1);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_ret_valid", ret_valid, 0);
      chk("rst_ret_half", ret_half, 0);
      chk("rst_ret_err", ret_err, 0);
      chk("rst_ret_data", ret_data, '0);
      e_rdy = 1; e_arv = 0; e_rr = 0; e_val = 0; e_half = 0;
      m_data = '0;
    end else begin
      chk("rd_rdy", rd_rdy, e_rdy);
      chk("arvalid", arvalid, e_arv);
      chk("rready", rready, e_rr);
      chk("ret_valid", ret_valid, e_val);
      chk("ret_half", ret_half, e_half);
      if (arvalid) begin
        chk("araddr", araddr, m_araddr);
        chk("arlen", arlen, 8'(m_arlen));
        chk("arcache", arcache, m_cache);
        chk("ar_fixed", {arid, arsize, arburst, arlock, arprot}, {4'd3, 3'd2, 2'b01, 2'b00, 3'd0});
        cap_araddr = araddr;
        cap_arlen  = arlen;
      end
      if (ret_valid) begin
        chk("ret_data", ret_data, m_data);
        chk("ret_err", ret_err, m_err);
        cap_data = ret_data; cap_err = ret_err; cyc_valid = cyc; n_valid++;
      end
      if (ret_half) begin
        chk("half_data", ret_data[127:0], m_data[127:0]);
        cyc_half = cyc; n_half++;
      end

      nx_rdy = e_rdy; nx_arv = e_arv; nx_rr = e_rr; nx_val = 0; nx_half = 0;
      if (e_rdy && rd_req) begin
        nx_rdy   = 0;
        nx_arv   = 1;
        m_type   = rd_type;
        m_arlen  = (rd_type == 2'b00) ? 0 : (rd_type == 2'b10) ? 7 : 3;
        m_araddr = (rd_type == 2'b00) ? rd_addr : {rd_addr[31:4], 4'h0};
        m_cache  = (rd_type == 2'b00) ? 4'b0000 : 4'b1111;
        m_err    = (rd_type == 2'b11);
        m_beats  = 0;
      end
      if (e_arv && arready) begin
        nx_arv = 0;
        nx_rr  = 1;
      end
      if (e_rr && rvalid) begin
        m_data[32*(m_beats % 8) +: 32] = rdata;
        if (rresp != 2'b00) m_err = 1;
        if (m_beats > m_arlen) m_err = 1;
        if (rlast && (m_beats != m_arlen)) m_err = 1;
        if ((m_type == 2'b10) && (m_beats == 3)) nx_half = 1;
        m_beats++;
        if (rlast) begin
          nx_rr  = 0;
          nx_val = 1;
        end
      end
      if (e_val) nx_rdy = 1;
      e_rdy = nx_rdy; e_arv = nx_arv; e_rr = nx_rr; e_val = nx_val; e_half = nx_half;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slave side of one request. rst_at >= 0 pulls resetn low before beat rst_at.
  task automatic run_txn(input logic [1:0] t, input logic [31:0] a, input int ar_wait,
                         input int gap_max, input int err_beat, input int last_at,
                         input logic [31:0] base, input logic [31:0] stride, input int rst_at);
    int k;
    logic acc, hs;
    rd_req = 1'b1; rd_type = t; rd_addr = a;
    k = 0;
    do begin acc = rd_rdy; step(); k++; end while (!acc && k < 50);
    rd_req = 1'b0;
    if (!acc) begin chk("req_accept_timeout", 0, 1); return; end
    k = 0;
    while (!arvalid && k < 20) begin step(); k++; end
    if (!arvalid) begin chk("arvalid_timeout", 0, 1); return; end
    repeat (ar_wait) step();
    arready = 1'b1; step(); arready = 1'b0;
    for (int i = 0; i <= last_at; i++) begin
      if (i == rst_at) begin
        chk("pre_rst_rready", rready, 1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_drop_arvalid", arvalid, 0);
        chk("rst_drop_rready", rready, 0);
        chk("rst_drop_ret_valid", ret_valid, 0);
        chk("rst_drop_ret_half", ret_half, 0);
        chk("rst_drop_rd_rdy", rd_rdy, 1);
        step(); step();
        resetn = 1'b1;
        step();
        return;
      end
      repeat ($urandom_range(gap_max, 0)) step();
      rvalid = 1'b1; rdata = base + stride * 32'(i);
      rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      rlast  = (i == last_at);
      k = 0;
      do begin hs = rready; step(); k++; end while (!hs && k < 20);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      if (!hs) begin chk("rready_timeout", 0, 1); return; end
    end
    k = 0;
    while (!rd_rdy && k < 20) begin step(); k++; end
    chk("txn_done_timeout", rd_rdy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hv, vv, t, nb, la, eb;
    logic [255:0] t3;
    repeat (3) step();
    resetn = 1'b1;
    step();

    // 1: uncached word
    hv = n_half; vv = n_valid;
    run_txn(2'b00, 32'h1fc0_0104, 0, 0, -1, 0, 32'hdeadbeef, 32'd0, -1);
    chk("t1_araddr", cap_araddr, 32'h1fc00104);
    chk("t1_arlen", cap_arlen, 8'd0);
    chk("t1_data", cap_data[31:0], 32'hdeadbeef);
    chk("t1_err", cap_err, 0);
    chk("t1_no_half", n_half - hv, 0);
    chk("t1_one_valid", n_valid - vv, 1);

    // 2: one line
    run_txn(2'b01, 32'h0000_1238, 0, 0, -1, 3, 32'h11, 32'h11, -1);
    chk("t2_araddr", cap_araddr, 32'h1230);
    chk("t2_arlen", cap_arlen, 8'd3);
    chk("t2_data", cap_data[127:0], 128'h00000044_00000033_00000022_00000011);

    // 3: two lines, zero-wait
    hv = n_half;
    run_txn(2'b10, 32'h0000_2000, 0, 0, -1, 7, 32'd0, 32'd1, -1);
    t3 = cap_data;
    chk("t3_half_count", n_half - hv, 1);
    chk("t3_half_to_valid", cyc_valid - cyc_half, 4);
    chk("t3_data", t3, 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);

    // 4: arready stall plus R gaps
    run_txn(2'b10, 32'h0000_2000, 5, 2, -1, 7, 32'd0, 32'd1, -1);
    chk("t4_data_same", cap_data, t3);

    // 5: error response, then early rlast
    run_txn(2'b01, 32'h0000_4010, 0, 0, 2, 3, 32'h100, 32'd1, -1);
    chk("t5_rresp_err", cap_err, 1);
    run_txn(2'b01, 32'h0000_4020, 0, 0, -1, 1, 32'h200, 32'd1, -1);
    chk("t5_early_last_err", cap_err, 1);
    chk("t5_back_idle", rd_rdy, 1);
    run_txn(2'b01, 32'h0000_4030, 0, 0, -1, 5, 32'h300, 32'd1, -1);
    chk("t5_late_last_err", cap_err, 1);
    run_txn(2'b11, 32'h0000_4040, 0, 0, -1, 3, 32'h400, 32'd1, -1);
    chk("t5_rsvd_err", cap_err, 1);

    // 6: reset mid-R, then a fresh line
    run_txn(2'b10, 32'h0000_3000, 0, 0, -1, 7, 32'h500, 32'd1, 3);
    chk("t6_post_rst_data", ret_data, '0);
    run_txn(2'b01, 32'h0000_5004, 0, 0, -1, 3, 32'h600, 32'd1, -1);
    chk("t6_err", cap_err, 0);
    chk("t6_data", cap_data, {128'd0, 128'h00000603_00000602_00000601_00000600});

    for (int n = 0; n < 40; n++) begin
      t  = int'($urandom_range(3, 0));
      nb = (t == 0) ? 1 : (t == 2) ? 8 : 4;
      la = nb - 1;
      case ($urandom_range(9, 0))
        0: if (nb > 1) la = nb - 2;
        1: la = nb;
        default: ;
      endcase
      eb = ($urandom_range(5, 0) == 0) ? int'($urandom_range(la, 0)) : -1;
      run_txn(2'(t), $urandom, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
              eb, la, $urandom, $urandom, -1);
    end

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
